procyon_ccu_sched: RTL
======================

// Module: procyon_ccu_sched
// PURPOSE
//  Multi-requester scheduler for the CCU bus interface unit (BIU). Arbitrates full-cacheline read/write requests from
//  MHQ fills, fetch misses and dcache victim writebacks, and sequences exactly one BIU transaction at a time.
//  Returns read data and a one-cycle done pulse to the winning requester. Sits between requesters and procyon_biu_wb.
// PARAMETERS
//  OPTN_ADDR_WIDTH    32  request/BIU address width
//  OPTN_DC_LINE_SIZE  32  line size in bytes; only 32 legal (elaboration-time $error otherwise)
//  OPTN_NUM_REQ       3   number of requesters; 1..8
//  OPTN_WR_PRIORITY   1   1: valid write requests beat all reads; 0: pure round-robin
//  DC_LINE_WIDTH      OPTN_DC_LINE_SIZE*8 (derived)
// PORTS
//  clk                 in   1                  clock
//  rst                 in   1                  async active-high reset
//  i_req_valid         in   OPTN_NUM_REQ       per-requester request; held with payload until its o_req_done
//  i_req_we            in   OPTN_NUM_REQ       1 = line write (victim), 0 = line read
//  i_req_addr          in   N x ADDR_WIDTH     unpacked array [0:OPTN_NUM_REQ-1]; line address
//  i_req_data          in   N x DC_LINE_WIDTH  unpacked array; write data (ignored for reads)
//  o_req_grant         out  OPTN_NUM_REQ       one-hot; requester owning the BIU (BUSY and DONE states)
//  o_req_done          out  OPTN_NUM_REQ       one-hot, one-cycle completion pulse
//  o_req_data          out  DC_LINE_WIDTH      read data, valid with o_req_done (shared by all requesters)
//  i_biu_done          in   1                  BIU transaction complete (one-cycle pulse)
//  i_biu_data          in   DC_LINE_WIDTH      BIU read data, valid with i_biu_done
//  o_biu_en            out  1                  BIU request; held high until i_biu_done
//  o_biu_func          out  PCYN_BIU_FUNC_WIDTH  READ/WRITE
//  o_biu_len           out  PCYN_BIU_LEN_WIDTH   constant PCYN_BIU_LEN_32B
//  o_biu_sel           out  OPTN_DC_LINE_SIZE  constant all-ones
//  o_biu_addr          out  ADDR_WIDTH         line-aligned address (low log2(LINE_SIZE) bits forced 0)
//  o_biu_data          out  DC_LINE_WIDTH      write data
// BEHAVIOUR
//  - Clocking: single clock clk; rst async active-high; all state and outputs registered.
//  - Reset: IDLE; o_req_grant/o_req_done/o_biu_en = 0; o_biu_func = READ.
//    o_biu_addr/o_biu_data/o_req_data = 0; RR pointer = 0.
//  - FSM IDLE -> BUSY -> DONE -> IDLE.
//  - IDLE: if any i_req_valid, pick winner W; latch W's we/addr/data into BIU regs; set o_req_grant[W]; -> BUSY.
//    Else stay.
//  - Winner selection: if OPTN_WR_PRIORITY and any valid&we, choose among writes only, else among all valid.
//    Round-robin from pointer P: lowest index >= P, wrapping to 0.
//  - BUSY: o_biu_en = 1, payload stable. On i_biu_done: latch i_biu_data into o_req_data (reads only; writes leave it).
//    Then pulse o_req_done[W], drop o_biu_en, P <= (W+1) mod OPTN_NUM_REQ, -> DONE.
//  - DONE: o_req_done high this cycle only, o_req_grant held; -> IDLE, grant cleared.
//    Requester must drop i_req_valid by the IDLE cycle.
//  - Latency: valid at cycle 0 -> o_biu_en at 1. i_biu_done at k -> o_req_done at k+1.
//    Back-to-back: next o_biu_en at k+3.
//  - Ordering: with OPTN_WR_PRIORITY=1, a pending victim write always issues before any read, so a refill
//    never overtakes a writeback of the same line.
//  - i_biu_done outside BUSY: ignored.
//  - i_req_valid deasserted by W during BUSY: protocol violation; the transaction still completes and done still pulses.
//  - Simultaneous requests: exactly one granted per arbitration; others wait, no starvation within a class.
//    Reads may starve under continuous writes when OPTN_WR_PRIORITY=1 (accepted).
//  - rst mid-transaction: immediate return to reset values (o_biu_en falls asynchronously). The BIU is reset on the
//    same reset; no done is pulsed.
// STRUCTURE
//  - Constants in procyon_constants.svh: PCYN_BIU_FUNC_READ/WRITE, PCYN_BIU_LEN_32B, widths. Add PCYN_CCU_SCHED_STATE_*
//    (2-bit encoding IDLE/BUSY/DONE) there.
//  - Sub-module procyon_rr_picker #(WIDTH): inputs mask and pointer; outputs one-hot pick and any-valid.
//    Instantiated twice (write mask, all mask); the write-first mux chooses between them.
// TESTING
//  1. Single read: req0 valid, addr 0x1000_0004 -> biu_en next cycle, addr 0x1000_0000, func READ.
//     done after BIU ack with data 0xA5.. -> o_req_done=001, o_req_data=0xA5..
//  2. RR fairness, WR_PRIORITY=0: reqs 0,1,2 read continuously -> grant order 0,1,2,0,1.
//     Each done exactly once per grant.
//  3. Write priority: read req0 and write req2 (addr 0x2000, data 0xDEAD..) in same cycle -> req2 granted first,
//     func WRITE, data 0xDEAD..; then req0.
//  4. Stray i_biu_done in IDLE and in DONE -> no o_req_done, state unchanged.
//  5. rst asserted in BUSY -> o_biu_en/o_req_grant 0 same cycle, no done.
//     After release a fresh req1 is granted, pointer 0.
//  6. BIU done held off 20 cycles -> o_biu_addr/func/data stable throughout, o_biu_en high until done.

Source files
------------

// File: rtl/procyon_ccu_sched_pkg.sv
// Shared BIU encodings, scheduler state type and sizing helper for the CCU scheduler.
// Imported by the interface, the round-robin picker and the scheduler top.
package procyon_ccu_sched_pkg;

    localparam int PCYN_BIU_FUNC_WIDTH = 3;
    localparam logic [PCYN_BIU_FUNC_WIDTH-1:0] PCYN_BIU_FUNC_READ  = 3'b000;
    localparam logic [PCYN_BIU_FUNC_WIDTH-1:0] PCYN_BIU_FUNC_WRITE = 3'b001;

    localparam int PCYN_BIU_LEN_WIDTH = 3;
    localparam logic [PCYN_BIU_LEN_WIDTH-1:0] PCYN_BIU_LEN_32B = 3'b011;

    typedef enum logic [1:0] {
        PCYN_CCU_SCHED_STATE_IDLE = 2'b00,
        PCYN_CCU_SCHED_STATE_BUSY = 2'b01,
        PCYN_CCU_SCHED_STATE_DONE = 2'b10
    } ccu_sched_state_t;

    // A single requester still needs a one-bit pointer so that port widths stay legal.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/procyon_ccu_sched_if.sv
// Requester and BIU signal bundle for the CCU scheduler.
// The scheduler uses the master modport; requesters plus the BIU sit on the slave side.
interface procyon_ccu_sched_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_SIZE  = 32,
    parameter int NUM_REQ    = 3
);
    import procyon_ccu_sched_pkg::*;

    localparam int LINE_WIDTH = LINE_SIZE * 8;

    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_we;
    logic [ADDR_WIDTH-1:0]          req_addr  [NUM_REQ];
    logic [LINE_WIDTH-1:0]          req_wdata [NUM_REQ];
    logic [NUM_REQ-1:0]             req_grant;
    logic [NUM_REQ-1:0]             req_done;
    logic [LINE_WIDTH-1:0]          req_rdata;

    logic                           biu_done;
    logic [LINE_WIDTH-1:0]          biu_rdata;
    logic                           biu_en;
    logic [PCYN_BIU_FUNC_WIDTH-1:0] biu_func;
    logic [PCYN_BIU_LEN_WIDTH-1:0]  biu_len;
    logic [LINE_SIZE-1:0]           biu_sel;
    logic [ADDR_WIDTH-1:0]          biu_addr;
    logic [LINE_WIDTH-1:0]          biu_wdata;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, biu_done, biu_rdata,
        output req_grant, req_done, req_rdata,
        output biu_en, biu_func, biu_len, biu_sel, biu_addr, biu_wdata
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, biu_done, biu_rdata,
        input  req_grant, req_done, req_rdata,
        input  biu_en, biu_func, biu_len, biu_sel, biu_addr, biu_wdata
    );

endinterface

// File: rtl/procyon_ccu_sched_rr_picker.sv
// Round-robin picker: one-hot choice of the lowest set mask bit at or above the pointer,
// wrapping to bit 0, plus an any-valid flag.
module procyon_ccu_sched_rr_picker #(
    parameter int WIDTH     = 3,
    parameter int PTR_WIDTH = 2
) (
    input  logic [WIDTH-1:0]     mask,
    input  logic [PTR_WIDTH-1:0] ptr,
    output logic [WIDTH-1:0]     pick,
    output logic                 any
);

    logic found;

    // First pass covers indices at or above the pointer; the second pass handles the wrap.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int j = 0; j < WIDTH; j++) begin
            if (!found && mask[j] && (j >= int'(ptr))) begin
                pick[j] = 1'b1;
                found   = 1'b1;
            end
        end
        for (int j = 0; j < WIDTH; j++) begin
            if (!found && mask[j]) begin
                pick[j] = 1'b1;
                found   = 1'b1;
            end
        end
    end

    assign any = |mask;

endmodule

// File: rtl/procyon_ccu_sched.sv
// CCU BIU scheduler: arbitrates full-line requests (writes first when enabled, otherwise
// round-robin) and runs exactly one BIU transaction at a time through IDLE/BUSY/DONE.
module procyon_ccu_sched
    import procyon_ccu_sched_pkg::*;
#(
    parameter int OPTN_ADDR_WIDTH   = 32,
    parameter int OPTN_DC_LINE_SIZE = 32,
    parameter int OPTN_NUM_REQ      = 3,
    parameter int OPTN_WR_PRIORITY  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    procyon_ccu_sched_if.master   bus
);

    localparam int DC_LINE_WIDTH = OPTN_DC_LINE_SIZE * 8;
    localparam int OFF_WIDTH     = $clog2(OPTN_DC_LINE_SIZE);
    localparam int PW            = ptr_width(OPTN_NUM_REQ);

    if (OPTN_DC_LINE_SIZE != 32) begin : g_bad_line_size
        $error("procyon_ccu_sched: OPTN_DC_LINE_SIZE must be 32");
    end
    if (OPTN_NUM_REQ < 1 || OPTN_NUM_REQ > 8) begin : g_bad_num_req
        $error("procyon_ccu_sched: OPTN_NUM_REQ must be 1..8");
    end

    ccu_sched_state_t               state;
    logic [PW-1:0]                  ptr;
    logic [PW-1:0]                  win;
    logic [OPTN_NUM_REQ-1:0]        grant;
    logic [OPTN_NUM_REQ-1:0]        done;
    logic                           biu_en;
    logic [PCYN_BIU_FUNC_WIDTH-1:0] func;
    logic [OPTN_ADDR_WIDTH-1:0]     addr;
    logic [DC_LINE_WIDTH-1:0]       wdata;
    logic [DC_LINE_WIDTH-1:0]       rdata;

    logic [OPTN_NUM_REQ-1:0]        wr_mask;
    logic [OPTN_NUM_REQ-1:0]        pick_wr;
    logic [OPTN_NUM_REQ-1:0]        pick_all;
    logic [OPTN_NUM_REQ-1:0]        pick;
    logic                           any_wr;
    logic                           any_all;
    logic [PW-1:0]                  pick_idx;

    assign wr_mask = bus.req_valid & bus.req_we;

    procyon_ccu_sched_rr_picker #(.WIDTH(OPTN_NUM_REQ), .PTR_WIDTH(PW)) u_pick_wr (
        .mask (wr_mask),
        .ptr  (ptr),
        .pick (pick_wr),
        .any  (any_wr)
    );

    procyon_ccu_sched_rr_picker #(.WIDTH(OPTN_NUM_REQ), .PTR_WIDTH(PW)) u_pick_all (
        .mask (bus.req_valid),
        .ptr  (ptr),
        .pick (pick_all),
        .any  (any_all)
    );

    // A pending victim writeback always goes out before any refill so a read never overtakes it.
    assign pick = ((OPTN_WR_PRIORITY != 0) && any_wr) ? pick_wr : pick_all;

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < OPTN_NUM_REQ; i++) begin
            if (pick[i]) pick_idx = PW'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= PCYN_CCU_SCHED_STATE_IDLE;
            ptr    <= '0;
            win    <= '0;
            grant  <= '0;
            done   <= '0;
            biu_en <= 1'b0;
            func   <= PCYN_BIU_FUNC_READ;
            addr   <= '0;
            wdata  <= '0;
            rdata  <= '0;
        end else begin
            case (state)
                PCYN_CCU_SCHED_STATE_IDLE: begin
                    done <= '0;
                    if (any_all) begin
                        grant  <= pick;
                        win    <= pick_idx;
                        func   <= bus.req_we[pick_idx] ? PCYN_BIU_FUNC_WRITE : PCYN_BIU_FUNC_READ;
                        addr   <= {bus.req_addr[pick_idx][OPTN_ADDR_WIDTH-1:OFF_WIDTH], OFF_WIDTH'(0)};
                        wdata  <= bus.req_wdata[pick_idx];
                        biu_en <= 1'b1;
                        state  <= PCYN_CCU_SCHED_STATE_BUSY;
                    end
                end
                PCYN_CCU_SCHED_STATE_BUSY: begin
                    if (bus.biu_done) begin
                        if (func == PCYN_BIU_FUNC_READ) rdata <= bus.biu_rdata;
                        done   <= grant;
                        biu_en <= 1'b0;
                        ptr    <= (win == PW'(OPTN_NUM_REQ - 1)) ? '0 : win + PW'(1);
                        state  <= PCYN_CCU_SCHED_STATE_DONE;
                    end
                end
                PCYN_CCU_SCHED_STATE_DONE: begin
                    done  <= '0;
                    grant <= '0;
                    state <= PCYN_CCU_SCHED_STATE_IDLE;
                end
                default: begin
                    state <= PCYN_CCU_SCHED_STATE_IDLE;
                end
            endcase
        end
    end

    assign bus.req_grant = grant;
    assign bus.req_done  = done;
    assign bus.req_rdata = rdata;
    assign bus.biu_en    = biu_en;
    assign bus.biu_func  = func;
    assign bus.biu_len   = PCYN_BIU_LEN_32B;
    assign bus.biu_sel   = '1;
    assign bus.biu_addr  = addr;
    assign bus.biu_wdata = wdata;

endmodule
